// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants and the immediate
// format encoding used by the decode stage and its immediate generator.
// The U-type formats (lui/auipc) are only decoded when the build defines
// IMM_DECODE_UTYPE_EN; the constants are always present.
package riscv_pkg;

  // 7-bit major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format selector as seen on out_immsrc
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // Register-field extraction shared by every format
  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Purely combinational opcode and immediate decode for one 32-bit
// instruction word. Produces the immediate format, the sign-extended
// immediate, the register fields and an illegal-opcode flag.
// Build option: IMM_DECODE_UTYPE_EN adds lui/auipc as U-type; without
// it those opcodes fall into the illegal path.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output imm_src_e        o_immsrc,
  output logic [XLEN-1:0] o_immext,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic            o_illegal
);

  logic [6:0]  w_opcode;
  logic [31:0] w_imm32;
  imm_src_e    w_src;
  logic        w_illegal;

  assign w_opcode = i_instr[6:0];

  // Opcode decode: pick the format and build the 32-bit sign-extended
  // immediate. R-type and anything illegal leave the immediate at zero so
  // nothing undefined ever reaches the outputs.
  always_comb begin
    w_src     = IMM_I;
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_src   = IMM_I;
        w_imm32 = '0;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_src   = IMM_I;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      OP_STORE: begin
        w_src   = IMM_S;
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      OP_BRANCH: begin
        w_src   = IMM_B;
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                   i_instr[30:25], i_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        w_src   = IMM_J;
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                   i_instr[20], i_instr[30:21], 1'b0};
      end
`ifdef IMM_DECODE_UTYPE_EN
      OP_LUI, OP_AUIPC: begin
        w_src   = IMM_U;
        w_imm32 = {i_instr[31:12], 12'b0};
      end
`endif
      default: begin
        w_src     = IMM_I;
        w_imm32   = '0;
        w_illegal = 1'b1;
      end
    endcase
  end

  // The 32-bit immediate is already sign-extended from instr[31]; a signed
  // size cast carries that sign on up to XLEN (a no-op when XLEN is 32).
  assign o_immext  = XLEN'(signed'(w_imm32));
  assign o_immsrc  = w_src;
  assign o_illegal = w_illegal;
  assign o_rd      = rd_of(i_instr);
  assign o_rs1     = rs1_of(i_instr);
  assign o_rs2     = rs2_of(i_instr);

endmodule

// File: rtl/imm_decode_stage.sv
// Single-entry pipeline stage around imm_gen: registers the decoded
// immediate and register fields behind a valid/ready handshake and keeps
// a saturating count of accepted illegal instructions.
// Build option: IMM_DECODE_UTYPE_EN (passed through to imm_gen) enables
// lui/auipc decode.
//
// Handshake: a beat moves in when in_valid && in_ready and out when
// out_valid && out_ready. in_ready = !out_valid || out_ready, so a held
// result blocks new input until the consumer takes it, and a result that
// leaves in the same cycle as a new one arrives is replaced without a
// bubble. Once out_valid is high the out_* fields are stable until taken.
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_immsrc,
  output logic [XLEN-1:0]  out_immext,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  imm_src_e        w_immsrc;
  logic [XLEN-1:0] w_immext;
  logic [4:0]      w_rd;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_illegal;
  logic            w_accept;

  logic             r_valid;
  logic [2:0]       r_immsrc;
  logic [XLEN-1:0]  r_immext;
  logic [4:0]       r_rd;
  logic [4:0]       r_rs1;
  logic [4:0]       r_rs2;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .i_instr   (in_instr),
    .o_immsrc  (w_immsrc),
    .o_immext  (w_immext),
    .o_rd      (w_rd),
    .o_rs1     (w_rs1),
    .o_rs2     (w_rs2),
    .o_illegal (w_illegal)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Output register: load on accept, drop valid when drained, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_immsrc  <= '0;
      r_immext  <= '0;
      r_rd      <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_immsrc  <= w_immsrc;
      r_immext  <= w_immext;
      r_rd      <= w_rd;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  // Illegal counter: bump on each accepted illegal word, stick at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept && w_illegal && !(&r_cnt)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_valid;
  assign out_immsrc  = r_immsrc;
  assign out_immext  = r_immext;
  assign out_rd      = r_rd;
  assign out_rs1     = r_rs1;
  assign out_rs2     = r_rs2;
  assign out_illegal = r_illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage. Expected values are hand-derived
// from the instruction encodings. Counter width is reduced so saturation
// is reachable in a few cycles.
module tb_imm_decode_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_immsrc;
  logic [XLEN-1:0]  out_immext;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [CNT_W-1:0] exp_cnt;
  logic [XLEN-1:0]  exp_q[$];

  imm_decode_stage #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_immsrc  (out_immsrc),
    .out_immext  (out_immext),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_cnt();
    if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  // back-to-back vector table
  localparam int NV = 6;
  logic [31:0] v_instr[NV];
  logic [2:0]  v_src[NV];
  logic [31:0] v_imm[NV];
  logic        v_ill[NV];

  initial begin
    // beq x0,x0,-4: instr[7]=1 lands in imm[11], giving -4
    v_instr[0] = 32'hFE000EE3; v_src[0] = 3'b010; v_imm[0] = 32'hFFFFFFFC; v_ill[0] = 1'b0;
    v_instr[1] = 32'h0000006F; v_src[1] = 3'b011; v_imm[1] = 32'h00000000; v_ill[1] = 1'b0;
    v_instr[2] = 32'hFFDFF0EF; v_src[2] = 3'b011; v_imm[2] = 32'hFFFFFFFC; v_ill[2] = 1'b0;
    v_instr[3] = 32'h80000067; v_src[3] = 3'b000; v_imm[3] = 32'hFFFFF800; v_ill[3] = 1'b0;
    v_instr[4] = 32'h002081B3; v_src[4] = 3'b000; v_imm[4] = 32'h00000000; v_ill[4] = 1'b0;
`ifdef IMM_DECODE_UTYPE_EN
    v_instr[5] = 32'h123450B7; v_src[5] = 3'b100; v_imm[5] = 32'h12345000; v_ill[5] = 1'b0;
`else
    v_instr[5] = 32'h123450B7; v_src[5] = 3'b000; v_imm[5] = 32'h00000000; v_ill[5] = 1'b1;
`endif
  end

  initial begin
    logic [CNT_W-1:0] cnt_before;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    exp_cnt = '0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_cnt", illegal_cnt, 0);
    check("rst_immext", out_immext, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    tick();

    // store word: sw x1,-4(x2)
    in_valid = 1'b1; in_instr = 32'hFE112E23; out_ready = 1'b1;
    #1;
    check("sw_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("sw_valid", out_valid, 1);
    check("sw_immsrc", out_immsrc, 3'b001);
    check("sw_immext", out_immext, 32'hFFFFFFFC);
    check("sw_rs1", out_rs1, 2);
    check("sw_rs2", out_rs2, 1);
    check("sw_rd", out_rd, 28);
    check("sw_illegal", out_illegal, 0);
    tick();
    check("sw_drain", out_valid, 0);

    // stall: addi x1,x0,5 held while a lw waits at the input
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093;
    tick();
    in_instr = 32'hFFC12083;
    for (int c = 0; c < 3; c++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_immext", out_immext, 32'h00000005);
      check("stall_rd", out_rd, 1);
      check("stall_rs1", out_rs1, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("swap_valid", out_valid, 1);
    check("swap_immext", out_immext, 32'hFFFFFFFC);
    check("swap_rs1", out_rs1, 2);
    tick();
    check("swap_drain", out_valid, 0);

    // back-to-back, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = v_instr[i];
      exp_q.push_back(v_imm[i]);
      tick();
      if (v_ill[i]) bump_cnt();
      check("b2b_valid", out_valid, 1);
      check("b2b_immext", out_immext, exp_q.pop_front());
      check("b2b_immsrc", out_immsrc, v_src[i]);
      check("b2b_illegal", out_illegal, v_ill[i]);
      check("b2b_cnt", illegal_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_drain", out_valid, 0);
    check("b2b_q_empty", exp_q.size(), 0);

    // an illegal word refused by a stall must not be counted twice
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F;
    tick();
    bump_cnt();
    cnt_before = illegal_cnt;
    check("stall_ill_cnt", cnt_before, exp_cnt);
    tick(); tick();
    check("stall_ill_hold", illegal_cnt, exp_cnt);
    check("stall_ill_flag", out_illegal, 1);
    check("stall_ill_immext", out_immext, 0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // saturation of the illegal counter
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1; in_instr = 32'h0000007F;
      tick();
      bump_cnt();
      check("sat_cnt", illegal_cnt, exp_cnt);
    end
    check("sat_all_ones", illegal_cnt, {CNT_W{1'b1}});
    in_valid = 1'b0;
    tick();

    // async reset between edges while a result is held
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFE112E23;
    tick();
    check("pre_arst_valid", out_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_cnt", illegal_cnt, 0);
    check("arst_immext", out_immext, 0);
    check("arst_immsrc", out_immsrc, 0);
    // input still presented across an edge in reset is discarded
    tick();
    check("arst_discard", out_valid, 0);
    reset = 1'b0; in_valid = 1'b0;
    tick();
    check("post_rst_valid", out_valid, 0);
    check("post_rst_cnt", illegal_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
